// File: rtl/bubble_sort_pkg.sv
// Shared types and constants for the bubble sort accelerator.
// Imported by the engine top and its compare/swap cell.
package bubble_sort_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SORT,
      FINISH
   } state_e;

   localparam logic DIR_ASC  = 1'b0;
   localparam logic DIR_DESC = 1'b1;

   function automatic int worst_compares(input int depth);
      return depth * (depth - 1) / 2;
   endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare/swap cell: orders one adjacent pair.
// lo_o lands at index j, hi_o at index j+1.
module sort_cmp_swap
   import bubble_sort_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int SIGNED_CMP = 0
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              dir_i,
   output logic [DATA_W-1:0] lo_o,
   output logic [DATA_W-1:0] hi_o,
   output logic              swap_o
);

   logic gt;
   logic lt;

   // Strict compare only, so equal keys keep their order
   always_comb begin
      if (SIGNED_CMP != 0) begin
         gt = $signed(a_i) > $signed(b_i);
         lt = $signed(a_i) < $signed(b_i);
      end else begin
         gt = a_i > b_i;
         lt = a_i < b_i;
      end
      swap_o = (dir_i == DIR_DESC) ? lt : gt;
      lo_o   = swap_o ? b_i : a_i;
      hi_o   = swap_o ? a_i : b_i;
   end

endmodule

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort accelerator, one compare per clock.
// Load in IDLE, pulse start, wait for done, read back.
module bubble_sort_engine
   import bubble_sort_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 10,
   parameter int SIGNED_CMP = 0,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              start_i,
   input  logic              descending_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [31:0]       swap_count_o,
   output logic [ADDR_W:0]   pass_count_o
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_J  = (ADDR_W + 1)'(DEPTH - 2);

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic              dir_q, dir_d;
   logic [ADDR_W-1:0] j_q, j_d;
   logic [ADDR_W-1:0] pass_q, pass_d;
   logic              swp_q, swp_d;
   logic [31:0]       swap_cnt_q, swap_cnt_d;
   logic [ADDR_W:0]   pass_cnt_q, pass_cnt_d;

   logic [ADDR_W-1:0] jp1;
   logic [DATA_W-1:0] lo, hi;
   logic              swap;
   logic              wr_ok;
   logic              pass_end;
   logic              more;

   assign jp1   = j_q + ADDR_W'(1);
   assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_W);

   // Window shrinks by one each pass: last j is DEPTH-2-pass
   assign pass_end = {1'b0, j_q} >= (LAST_J - {1'b0, pass_q});
   assign more     = (swp_q | swap) && ({1'b0, pass_q} < LAST_J);

   sort_cmp_swap #(
      .DATA_W    (DATA_W),
      .SIGNED_CMP(SIGNED_CMP)
   ) u_cmp (
      .a_i   (mem_q[j_q]),
      .b_i   (mem_q[jp1]),
      .dir_i (dir_q),
      .lo_o  (lo),
      .hi_o  (hi),
      .swap_o(swap)
   );

   // Next-state logic for the sort sequencer
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      j_d        = j_q;
      pass_d     = pass_q;
      swp_d      = swp_q;
      swap_cnt_d = swap_cnt_q;
      pass_cnt_d = pass_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = SORT;
               dir_d      = descending_i;
               j_d        = '0;
               pass_d     = '0;
               swp_d      = 1'b0;
               swap_cnt_d = '0;
               pass_cnt_d = (ADDR_W + 1)'(1);
            end
         end
         SORT: begin
            if (swap) begin
               swap_cnt_d = swap_cnt_q + 32'd1;
               swp_d      = 1'b1;
            end
            if (!pass_end) begin
               j_d = jp1;
            end else if (more) begin
               pass_d     = pass_q + ADDR_W'(1);
               j_d        = '0;
               swp_d      = 1'b0;
               pass_cnt_d = pass_cnt_q + (ADDR_W + 1)'(1);
            end else begin
               state_d = FINISH;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; reset abandons any sort in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         dir_q      <= DIR_ASC;
         j_q        <= '0;
         pass_q     <= '0;
         swp_q      <= 1'b0;
         swap_cnt_q <= '0;
         pass_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         j_q        <= j_d;
         pass_q     <= pass_d;
         swp_q      <= swp_d;
         swap_cnt_q <= swap_cnt_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end

   // Element storage: loads in IDLE, atomic pair swaps in SORT
   always_ff @(posedge clk) begin
      if (state_q == IDLE && wr_ok) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end else if (state_q == SORT && swap) begin
         mem_q[j_q] <= lo;
         mem_q[jp1] <= hi;
      end
   end

   assign rd_data_o    = ({1'b0, rd_addr_i} < DEPTH_W) ? mem_q[rd_addr_i] : '0;
   assign busy_o       = (state_q == SORT);
   assign done_o       = (state_q == FINISH);
   assign swap_count_o = swap_cnt_q;
   assign pass_count_o = pass_cnt_q;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine.
// Reference is rank/inversion arithmetic, not a stepwise sort.
module tb_bubble_sort_engine;
   import bubble_sort_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, start, desc;
   logic [3:0]  wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data, swap_count;
   logic [4:0]  pass_count;
   logic        busy, done;

   logic        s_wr_en, s_start, s_desc;
   logic [1:0]  s_wr_addr, s_rd_addr;
   logic [7:0]  s_wr_data;
   logic [7:0]  ss_rd, su_rd;
   logic        ss_busy, ss_done, su_busy, su_done;
   logic [31:0] ss_swaps, su_swaps;
   logic [2:0]  ss_pass, su_pass;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bubble_sort_engine u_dut (
      .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .start_i(start), .descending_i(desc),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data), .busy_o(busy),
      .done_o(done), .swap_count_o(swap_count), .pass_count_o(pass_count)
   );

   bubble_sort_engine #(.DATA_W(8), .DEPTH(4), .SIGNED_CMP(1)) u_s (
      .clk(clk), .rst(rst), .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr),
      .wr_data_i(s_wr_data), .start_i(s_start), .descending_i(s_desc),
      .rd_addr_i(s_rd_addr), .rd_data_o(ss_rd), .busy_o(ss_busy),
      .done_o(ss_done), .swap_count_o(ss_swaps), .pass_count_o(ss_pass)
   );

   bubble_sort_engine #(.DATA_W(8), .DEPTH(4), .SIGNED_CMP(0)) u_u (
      .clk(clk), .rst(rst), .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr),
      .wr_data_i(s_wr_data), .start_i(s_start), .descending_i(s_desc),
      .rd_addr_i(s_rd_addr), .rd_data_o(su_rd), .busy_o(su_busy),
      .done_o(su_done), .swap_count_o(su_swaps), .pass_count_o(su_pass)
   );

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model
   longint mk[16];
   int     mn;
   bit     mdesc;
   int     m_idx[16];
   int     m_swaps, m_passes, m_cmps;

   function automatic bit after(input longint x, input longint y, input bit d);
      return d ? (x < y) : (x > y);
   endfunction

   function automatic void run_model();
      int lft, mx, r;
      m_swaps = 0;
      mx = 0;
      for (int i = 0; i < mn; i++) begin
         lft = 0;
         r = 0;
         for (int j = 0; j < mn; j++) begin
            if (j < i && after(mk[j], mk[i], mdesc)) lft++;
            if (after(mk[i], mk[j], mdesc)) r++;
            else if (j < i && mk[j] == mk[i]) r++;
         end
         m_swaps += lft;
         if (lft > mx) mx = lft;
         m_idx[r] = i;
      end
      m_passes = (mx + 1 < mn - 1) ? mx + 1 : mn - 1;
      m_cmps = 0;
      for (int p = 0; p < m_passes; p++) m_cmps += mn - 1 - p;
   endfunction

   // Per-cycle busy/done check against the model's compare count
   bit chk_en = 1'b0;
   int chk_k, chk_C;
   always @(posedge clk) begin
      if (chk_en) begin
         #1;
         check("busy", busy, chk_k < chk_C);
         check("done", done, chk_k == chk_C);
         if (chk_k >= chk_C + 2) chk_en = 1'b0;
         chk_k++;
      end
   end

   int last_lat;

   task automatic load_main(input logic [31:0] v[10]);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = v[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic run_main(input logic [31:0] v[10], input bit d,
                           input bit disturb);
      int n;
      bit got;
      for (int i = 0; i < 10; i++) mk[i] = longint'(v[i]);
      mn = 10; mdesc = d;
      run_model();
      load_main(v);
      start = 1'b1; desc = d;
      chk_C = m_cmps; chk_k = 0; chk_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1; got = 1'b0;
      while (!got && n < 3000) begin
         if (done) begin
            got = 1'b1;
            start = 1'b1;
         end else begin
            if (disturb && n == 3) begin
               desc = ~desc; wr_en = 1'b1; wr_addr = 4'd0;
               wr_data = 32'hDEAD_BEEF; start = 1'b1;
            end
            if (n == 4) begin
               wr_en = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            n++;
         end
      end
      if (!got) begin
         check("done_timeout", 0, 1);
         chk_en = 1'b0;
         wr_en = 1'b0;
      end
      last_lat = n;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("latency", n, m_cmps + 1);
      check("swap_count", swap_count, m_swaps);
      check("pass_count", pass_count, m_passes);
      for (int i = 0; i < 10; i++) begin
         rd_addr = 4'(i);
         #1;
         check("readback", rd_data, v[m_idx[i]]);
      end
   endtask

   task automatic lit_main(input string nm, input logic [31:0] e[10]);
      for (int i = 0; i < 10; i++) begin
         rd_addr = 4'(i);
         #1;
         check(nm, rd_data, e[i]);
      end
   endtask

   task automatic run_small(input logic [7:0] v[4], input bit d);
      logic [7:0] es[4], eu[4];
      int sw_s, sw_u, ps_s, ps_u, c_s, c_u, ns, nu, n;
      mn = 4; mdesc = d;
      for (int i = 0; i < 4; i++) mk[i] = longint'($signed(v[i]));
      run_model();
      for (int i = 0; i < 4; i++) es[i] = v[m_idx[i]];
      sw_s = m_swaps; ps_s = m_passes; c_s = m_cmps;
      for (int i = 0; i < 4; i++) mk[i] = longint'(v[i]);
      run_model();
      for (int i = 0; i < 4; i++) eu[i] = v[m_idx[i]];
      sw_u = m_swaps; ps_u = m_passes; c_u = m_cmps;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s_wr_en = 1'b1; s_wr_addr = 2'(i); s_wr_data = v[i];
      end
      @(negedge clk);
      s_wr_en = 1'b0; s_start = 1'b1; s_desc = d;
      @(negedge clk);
      s_start = 1'b0;
      ns = 0; nu = 0; n = 1;
      while ((ns == 0 || nu == 0) && n < 200) begin
         if (ss_done && ns == 0) ns = n;
         if (su_done && nu == 0) nu = n;
         @(negedge clk);
         n++;
      end
      check("s_latency", ns, c_s + 1);
      check("u_latency", nu, c_u + 1);
      check("s_swaps", ss_swaps, sw_s);
      check("u_swaps", su_swaps, sw_u);
      check("s_passes", ss_pass, ps_s);
      check("u_passes", su_pass, ps_u);
      for (int i = 0; i < 4; i++) begin
         s_rd_addr = 2'(i);
         #1;
         check("s_readback", ss_rd, es[i]);
         check("u_readback", su_rd, eu[i]);
      end
   endtask

   logic [31:0] t1[10]  = '{1000, 800, 23, 384, 342, 234, 0, 65, 9, 290};
   logic [31:0] t1a[10] = '{0, 9, 23, 65, 234, 290, 342, 384, 800, 1000};
   logic [31:0] t1d[10] = '{1000, 800, 384, 342, 290, 234, 65, 23, 9, 0};
   logic [31:0] asc[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
   logic [31:0] rev[10] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
   logic [7:0]  t5[4]   = '{8'hFF, 8'h01, 8'h80, 8'h01};
   logic [7:0]  t5s[4]  = '{8'h80, 8'hFF, 8'h01, 8'h01};
   logic [7:0]  t5u[4]  = '{8'h01, 8'h01, 8'h80, 8'hFF};
   logic [7:0]  pool[6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h40};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rv[10];
      logic [7:0]  sv[4];
      int cnt;
      rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
      desc = 1'b0; rd_addr = '0;
      s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_start = 1'b0;
      s_desc = 1'b0; s_rd_addr = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_swaps", swap_count, 0);
      check("rst_passes", pass_count, 0);
      rst = 1'b0;

      run_main(t1, 1'b0, 1'b0);
      lit_main("t1_result", t1a);

      run_main(asc, 1'b0, 1'b0);
      check("t2_latency", last_lat, 10);
      check("t2_passes", pass_count, 1);
      check("t2_swaps", swap_count, 0);

      run_main(rev, 1'b0, 1'b0);
      check("t3_swaps", swap_count, 45);
      check("t3_passes", pass_count, 9);
      check("t3_latency", last_lat, 46);
      check("t3_worst", m_cmps, worst_compares(10));
      lit_main("t3_result", asc);

      run_main(t1, 1'b1, 1'b1);
      lit_main("t4_result", t1d);

      run_small(t5, 1'b0);
      for (int i = 0; i < 4; i++) begin
         s_rd_addr = 2'(i);
         #1;
         check("t5_signed", ss_rd, t5s[i]);
         check("t5_unsigned", su_rd, t5u[i]);
      end

      load_main(rev);
      start = 1'b1; desc = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_swaps", swap_count, 0);
      check("t6_passes", pass_count, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int val = 0; val < 10; val++) begin
         cnt = 0;
         for (int i = 0; i < 10; i++) begin
            rd_addr = 4'(i);
            #1;
            if (rd_data == 32'(val)) cnt++;
         end
         check("t6_perm", cnt, 1);
      end

      for (int t = 0; t < 15; t++) begin
         for (int i = 0; i < 10; i++)
            rv[i] = t[0] ? $urandom() : 32'($urandom_range(0, 7));
         run_main(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 4; i++)
            sv[i] = t[0] ? 8'($urandom()) : pool[$urandom_range(0, 5)];
         run_small(sv, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
